frame_writer: RTL and testbench

- Upstream neighbour of the VGA controller. Owns the 320x240 framebuffer of 2-bit raw pixels.
- Write side: accepts a valid/ready pixel stream with start-of-frame and end-of-line markers, and generates write addresses.
- Read side: returns pixel data to the controller from its 17-bit read address with 1-cycle latency.
- Runs entirely in the pixel clock domain.

---
 rtl/frame_writer_if.sv | 33 +++
 rtl/frame_writer.sv | 212 +++++++++++++++++++++
 tb/tb_frame_writer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_writer_if
//  Brief    : Pixel stream bundle (valid/ready with sof/eol markers) feeding
//             the frame writer.
//  Revision : 1.0
// ============================================================================
interface frame_writer_if #(
    parameter int PIX_W = 2
);
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;
    logic             pix_eol;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_sof,
        output pix_eol,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_sof,
        input  pix_eol,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_writer
//  Brief    : Writes a sof/eol-framed pixel stream into a 2-bit framebuffer and
//             serves 1-cycle-latency reads to the VGA controller. Defining
//             DOUBLE_BUFFER_EN adds a second bank swapped on vsync fall.
//  Revision : 1.0
// ============================================================================
module frame_writer #(
    parameter int H_PIXELS = 320,
    parameter int V_PIXELS = 240,
    parameter int ADDR_W   = 17,
    parameter int PIX_W    = 2
) (
    input  wire                vga_clk_25,
    input  wire                reset_n,
    frame_writer_if.slave      pix,
    input  wire [ADDR_W-1:0]   rd_addr,
    output logic [PIX_W-1:0]   rd_data,
    input  wire                vsync,
    output logic               frame_done,
    output logic               line_err
);

    localparam int c_FB_SIZE = H_PIXELS * V_PIXELS;
    localparam int c_X_W     = $clog2(H_PIXELS + 1);
    localparam int c_Y_W     = $clog2(V_PIXELS + 1);
`ifdef DOUBLE_BUFFER_EN
    localparam int c_BANKS   = 2;
`else
    localparam int c_BANKS   = 1;
`endif
    localparam int c_IDX_W   = $clog2(c_BANKS * c_FB_SIZE);

    localparam logic [c_X_W-1:0]  c_H           = c_X_W'(H_PIXELS);
    localparam logic [c_X_W-1:0]  c_H_LAST      = c_X_W'(H_PIXELS - 1);
    localparam logic [c_Y_W-1:0]  c_V_LAST      = c_Y_W'(V_PIXELS - 1);
    localparam logic [ADDR_W-1:0] c_LINE_STRIDE = ADDR_W'(H_PIXELS);
    localparam logic [ADDR_W:0]   c_FB_LIMIT    = (ADDR_W + 1)'(c_FB_SIZE);

    localparam logic [1:0] c_S_WAIT_SOF = 2'd0;
    localparam logic [1:0] c_S_WRITE    = 2'd1;
    localparam logic [1:0] c_S_COMMIT   = 2'd2;

    logic [1:0]        r_state,     w_state_nxt;
    logic [c_X_W-1:0]  r_x,         w_x_nxt;
    logic [c_Y_W-1:0]  r_y,         w_y_nxt;
    logic [ADDR_W-1:0] r_wr_addr,   w_wr_addr_nxt;
    logic [ADDR_W-1:0] r_line_base, w_line_base_nxt;
    logic              r_line_err,  w_line_err_nxt;
    logic              r_rst_done;
    logic [PIX_W-1:0]  r_rd_data;

    logic              w_ready;
    logic              w_accept;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_frame_done;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic              w_rd_in_range;

    logic [PIX_W-1:0]  r_mem [0:c_BANKS*c_FB_SIZE-1];

`ifdef DOUBLE_BUFFER_EN
    logic r_disp_bank, w_disp_bank_nxt;
    logic r_vsync_q;
    logic w_vsync_fall;

    assign w_vsync_fall = r_vsync_q & ~vsync;
    // Writes target the hidden bank; the controller only ever sees the display bank.
    assign w_wr_idx = c_IDX_W'(w_wr_addr) + (r_disp_bank ? c_IDX_W'(0) : c_IDX_W'(c_FB_SIZE));
    assign w_rd_idx = c_IDX_W'(rd_addr) + (r_disp_bank ? c_IDX_W'(c_FB_SIZE) : c_IDX_W'(0));
`else
    logic w_unused_vsync;

    assign w_unused_vsync = vsync;
    assign w_wr_idx       = c_IDX_W'(w_wr_addr);
    assign w_rd_idx       = c_IDX_W'(rd_addr);
`endif

    assign w_ready       = reset_n & r_rst_done & (r_state != c_S_COMMIT);
    assign w_accept      = pix.pix_valid & w_ready;
    assign w_rd_in_range = ({1'b0, rd_addr} < c_FB_LIMIT);

    assign pix.pix_ready = w_ready;
    assign rd_data       = r_rd_data;
    assign frame_done    = w_frame_done & reset_n;
    assign line_err      = r_line_err;

    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_wr_addr_nxt   = r_wr_addr;
        w_line_base_nxt = r_line_base;
        w_line_err_nxt  = r_line_err;
        w_wr_en         = 1'b0;
        w_wr_addr       = r_wr_addr;
        w_frame_done    = 1'b0;
`ifdef DOUBLE_BUFFER_EN
        w_disp_bank_nxt = r_disp_bank;
`endif
        case (r_state)
            c_S_WAIT_SOF: begin
                if (w_accept && pix.pix_sof) begin
                    w_wr_en         = 1'b1;
                    w_wr_addr       = '0;
                    w_x_nxt         = c_X_W'(1);
                    w_y_nxt         = '0;
                    w_wr_addr_nxt   = ADDR_W'(1);
                    w_line_base_nxt = '0;
                    w_state_nxt     = c_S_WRITE;
                end
            end
            c_S_WRITE: begin
                if (w_accept) begin
                    if (pix.pix_sof) begin
                        w_wr_en         = 1'b1;
                        w_wr_addr       = '0;
                        w_x_nxt         = c_X_W'(1);
                        w_y_nxt         = '0;
                        w_wr_addr_nxt   = ADDR_W'(1);
                        w_line_base_nxt = '0;
                        w_line_err_nxt  = 1'b1;
                    end else if (pix.pix_eol) begin
                        // Line base advances by a stride so no multiplier is needed.
                        w_wr_en         = (r_x < c_H);
                        if (r_x != c_H_LAST) begin
                            w_line_err_nxt = 1'b1;
                        end
                        w_x_nxt         = '0;
                        w_y_nxt         = r_y + c_Y_W'(1);
                        w_line_base_nxt = r_line_base + c_LINE_STRIDE;
                        w_wr_addr_nxt   = r_line_base + c_LINE_STRIDE;
                        if (r_y == c_V_LAST) begin
                            w_state_nxt = c_S_COMMIT;
                        end
                    end else if (r_x < c_H) begin
                        w_wr_en       = 1'b1;
                        w_x_nxt       = r_x + c_X_W'(1);
                        w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
                    end else begin
                        w_line_err_nxt = 1'b1;
                    end
                end
            end
            c_S_COMMIT: begin
`ifdef DOUBLE_BUFFER_EN
                if (w_vsync_fall) begin
                    w_frame_done    = 1'b1;
                    w_disp_bank_nxt = ~r_disp_bank;
                    w_state_nxt     = c_S_WAIT_SOF;
                end
`else
                w_frame_done = 1'b1;
                w_state_nxt  = c_S_WAIT_SOF;
`endif
            end
            default: begin
                w_state_nxt = c_S_WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge vga_clk_25) begin
        if (!reset_n) begin
            r_state     <= c_S_WAIT_SOF;
            r_x         <= '0;
            r_y         <= '0;
            r_wr_addr   <= '0;
            r_line_base <= '0;
            r_line_err  <= 1'b0;
            r_rst_done  <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
            r_disp_bank <= 1'b0;
            r_vsync_q   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_line_base <= w_line_base_nxt;
            r_line_err  <= w_line_err_nxt;
            r_rst_done  <= 1'b1;
`ifdef DOUBLE_BUFFER_EN
            r_disp_bank <= w_disp_bank_nxt;
            r_vsync_q   <= vsync;
`endif
        end
    end

    // RAM is never cleared; the registered read samples before the write lands.
    always_ff @(posedge vga_clk_25) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= pix.pix_data;
        end
    end

    always_ff @(posedge vga_clk_25) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[w_rd_idx];
        end else begin
            r_rd_data <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_writer
//  Brief    : Directed self-checking bench for frame_writer.
//  Revision : 1.0
// ============================================================================
module tb_frame_writer;

    localparam int H = 320;
    localparam int V = 240;

    logic        vga_clk_25 = 1'b0;
    logic        reset_n;
    logic [16:0] rd_addr;
    logic [1:0]  rd_data;
    logic        vsync;
    logic        frame_done;
    logic        line_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;

    frame_writer_if #(.PIX_W(2)) pix_if ();

    frame_writer #(
        .H_PIXELS (H),
        .V_PIXELS (V),
        .ADDR_W   (17),
        .PIX_W    (2)
    ) dut (
        .vga_clk_25 (vga_clk_25),
        .reset_n    (reset_n),
        .pix        (pix_if),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .vsync      (vsync),
        .frame_done (frame_done),
        .line_err   (line_err)
    );

    always #5 vga_clk_25 = ~vga_clk_25;

    always @(negedge vga_clk_25) begin
        if (frame_done === 1'b1) n_done++;
    end

    task automatic beat(input logic [1:0] d, input logic sof, input logic eol);
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = d;
        pix_if.pix_sof   = sof;
        pix_if.pix_eol   = eol;
        @(posedge vga_clk_25); #1;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_sof   = 1'b0;
        pix_if.pix_eol   = 1'b0;
    endtask

    task automatic read_px(input logic [16:0] a, output logic [1:0] d);
        rd_addr = a;
        @(posedge vga_clk_25); #1;
        d = rd_data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; vsync = 1'b1; rd_addr = '0;
        pix_if.pix_valid = 1'b0; pix_if.pix_data = '0;
        pix_if.pix_sof = 1'b0; pix_if.pix_eol = 1'b0;
        repeat (3) @(posedge vga_clk_25);
        #1;
        n_cmp++; if (pix_if.pix_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", pix_if.pix_ready); end
        n_cmp++; if (rd_data !== 2'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_cmp++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL reset_line_err: got %b expected 0", line_err); end
        reset_n = 1'b1;
        @(posedge vga_clk_25); #1;
        n_cmp++; if (pix_if.pix_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", pix_if.pix_ready); end
    endtask

`ifdef DOUBLE_BUFFER_EN
    task automatic test_double_buffer();
        logic [1:0] d;
        int ready_hi;
        int seen;
        ready_hi = 0;
        seen = 0;
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                beat(2'(xx + yy), (xx == 0 && yy == 0), (xx == H - 1));
        for (int k = 0; k < 6; k++) begin
            if (pix_if.pix_ready !== 1'b0) ready_hi++;
            @(posedge vga_clk_25); #1;
        end
        n_cmp++; if (ready_hi != 0) begin n_fail++; $display("FAIL db_hold_ready: got %0d ready cycles expected 0", ready_hi); end
        n_cmp++; if (n_done != 0) begin n_fail++; $display("FAIL db_early_done: got %0d pulses expected 0", n_done); end
        vsync = 1'b0;
        for (int k = 0; k < 4 && seen == 0; k++) begin
            @(negedge vga_clk_25);
            if (frame_done === 1'b1) seen = 1;
        end
        n_cmp++; if (seen != 1) begin n_fail++; $display("FAIL db_done_on_vsync: got %0d expected 1", seen); end
        for (int k = 0; k < 4 && pix_if.pix_ready !== 1'b1; k++) begin
            @(posedge vga_clk_25); #1;
        end
        n_cmp++; if (pix_if.pix_ready !== 1'b1) begin n_fail++; $display("FAIL db_ready_after: got %b expected 1", pix_if.pix_ready); end
        read_px(17'd321, d);
        n_cmp++; if (d !== 2'd2) begin n_fail++; $display("FAIL db_rd_321: got %0d expected 2", d); end
        read_px(17'd76799, d);
        n_cmp++; if (d !== 2'd2) begin n_fail++; $display("FAIL db_rd_last: got %0d expected 2", d); end
        n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL db_done_count: got %0d expected 1", n_done); end
        n_cmp++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL db_line_err: got %b expected 0", line_err); end
    endtask
`else
    task automatic test_full_frame();
        logic [1:0] d;
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                beat(2'(xx + yy), (xx == 0 && yy == 0), (xx == H - 1));
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_pulse: got %b expected 1", frame_done); end
        n_cmp++; if (pix_if.pix_ready !== 1'b0) begin n_fail++; $display("FAIL commit_ready: got %b expected 0", pix_if.pix_ready); end
        @(posedge vga_clk_25); #1;
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_width: got %b expected 0", frame_done); end
        n_cmp++; if (pix_if.pix_ready !== 1'b1) begin n_fail++; $display("FAIL post_commit_ready: got %b expected 1", pix_if.pix_ready); end
        n_cmp++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL frame_line_err: got %b expected 0", line_err); end
        read_px(17'd321, d);
        n_cmp++; if (d !== 2'd2) begin n_fail++; $display("FAIL rd_321: got %0d expected 2", d); end
        read_px(17'd76799, d);
        n_cmp++; if (d !== 2'd2) begin n_fail++; $display("FAIL rd_last: got %0d expected 2", d); end
        read_px(17'd76800, d);
        n_cmp++; if (d !== 2'd0) begin n_fail++; $display("FAIL rd_out_of_range: got %0d expected 0", d); end
        n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d expected 1", n_done); end
    endtask

    // Second frame uses pattern (x+y+1)&3 so it differs from the first frame.
    task automatic test_sof_drop();
        logic [1:0] d;
        for (int k = 0; k < 3; k++) beat(2'd2, 1'b0, 1'b0);
        n_cmp++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL drop_line_err: got %b expected 0", line_err); end
        beat(2'd1, 1'b1, 1'b0);
        read_px(17'd0, d);
        n_cmp++; if (d !== 2'd1) begin n_fail++; $display("FAIL sof_addr0: got %0d expected 1", d); end
        read_px(17'd1, d);
        n_cmp++; if (d !== 2'd1) begin n_fail++; $display("FAIL drop_addr1: got %0d expected 1", d); end
    endtask

    task automatic test_long_line();
        logic [1:0] d;
        for (int xx = 1; xx < 330; xx++) beat(2'(xx + 1), 1'b0, (xx == 329));
        n_cmp++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL long_line_err: got %b expected 1", line_err); end
        read_px(17'd318, d);
        n_cmp++; if (d !== 2'd3) begin n_fail++; $display("FAIL long_addr318: got %0d expected 3", d); end
        read_px(17'd319, d);
        n_cmp++; if (d !== 2'd0) begin n_fail++; $display("FAIL long_addr319: got %0d expected 0", d); end
        read_px(17'd320, d);
        n_cmp++; if (d !== 2'd1) begin n_fail++; $display("FAIL long_no_spill_320: got %0d expected 1", d); end
    endtask

    task automatic test_mid_reset();
        logic [1:0] d;
        int cx;
        int cy;
        cx = 0;
        cy = 1;
        for (int i = 0; i < 1000; i++) begin
            beat(2'(cx + cy + 1), 1'b0, (cx == H - 1));
            if (cx == H - 1) begin cx = 0; cy++; end
            else cx++;
        end
        reset_n = 1'b0;
        @(posedge vga_clk_25); #1;
        n_cmp++; if (pix_if.pix_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 0", pix_if.pix_ready); end
        n_cmp++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_line_err: got %b expected 0", line_err); end
        reset_n = 1'b1;
        @(posedge vga_clk_25); #1;
        n_cmp++; if (pix_if.pix_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b expected 1", pix_if.pix_ready); end
        beat(2'd0, 1'b0, 1'b0);
        read_px(17'd0, d);
        n_cmp++; if (d !== 2'd1) begin n_fail++; $display("FAIL mid_drop_addr0: got %0d expected 1", d); end
        read_px(17'd1319, d);
        n_cmp++; if (d !== 2'd0) begin n_fail++; $display("FAIL mid_partial_kept: got %0d expected 0", d); end
    endtask

    // Third frame uses pattern (x+y+2)&3; line 5 carries 100 pixels, eol on the 100th.
    task automatic test_short_line();
        logic [1:0] d;
        for (int yy = 0; yy < 5; yy++)
            for (int xx = 0; xx < H; xx++)
                beat(2'(xx + yy + 2), (xx == 0 && yy == 0), (xx == H - 1));
        n_cmp++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL short_pre_err: got %b expected 0", line_err); end
        for (int xx = 0; xx < 100; xx++) beat(2'(xx + 7), 1'b0, (xx == 99));
        n_cmp++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL short_line_err: got %b expected 1", line_err); end
        for (int xx = 0; xx < 5; xx++) beat(2'(xx + 8), 1'b0, 1'b0);
        read_px(17'd1920, d);
        n_cmp++; if (d !== 2'd0) begin n_fail++; $display("FAIL short_next_line_1920: got %0d expected 0", d); end
        read_px(17'd1699, d);
        n_cmp++; if (d !== 2'd2) begin n_fail++; $display("FAIL short_last_1699: got %0d expected 2", d); end
        read_px(17'd1700, d);
        n_cmp++; if (d !== 2'd1) begin n_fail++; $display("FAIL short_tail_1700: got %0d expected 1", d); end
        read_px(17'd1919, d);
        n_cmp++; if (d !== 2'd0) begin n_fail++; $display("FAIL short_tail_1919: got %0d expected 0", d); end
        n_cmp++; if (n_done != 1) begin n_fail++; $display("FAIL total_done_count: got %0d expected 1", n_done); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef DOUBLE_BUFFER_EN
        test_double_buffer();
`else
        test_full_frame();
        test_sof_drop();
        test_long_line();
        test_mid_reset();
        test_short_line();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
